jk_drive_seq: RTL

- Controller that generates J/K excitation for an external bank of W JK flip-flops (JKFF-style: Q+ = J·~Q | ~K·Q).
- Moves the bank from its current value to a requested target.
- Changes one bit per clock, lowest differing bit first.
- Keeps an internal shadow of the bank so that q_mirror always equals the bank's Q when both share Clk/rst.

---
 rtl/jk_drive_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: steps an external JK flip-flop bank from its current value
// to a requested target. Each clock it changes one bit, starting with the
// lowest bit that differs. An internal shadow (q_mirror) tracks the bank.
// Build option: define JK_TOGGLE_EN to drive the changing bit with J=K=1
// (toggle). Without it, the bit gets set (J=1) or reset (K=1).

module jk_drive_lane (
  input  logic sel,
  input  logic t,
  output logic j,
  output logic k
);
  // Per-bit J/K encode for the one bit that is moving this cycle
  always_comb begin
`ifdef JK_TOGGLE_EN
    j = sel;
    k = sel;
`else
    j = sel & t;
    k = sel & ~t;
`endif
  end
endmodule

module jk_drive_seq #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] tgt,
  input  logic         abort,
  output logic [W-1:0] J,
  output logic [W-1:0] K,
  output logic [W-1:0] q_mirror,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t       state, state_nx;
  logic [W-1:0] s_q, t_q, s_nx, t_nx;
  logic [W-1:0] diff, pick, step_sel;

  // Isolate the lowest differing bit: x & -x keeps only the lowest set bit
  assign diff     = s_q ^ t_q;
  assign pick     = diff & (~diff + W'(1));
  assign step_sel = (state == STEP) ? pick : '0;
  assign q_mirror = s_q;

  // State, shadow and target registers
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s_q   <= '0;
      t_q   <= '0;
    end else begin
      state <= state_nx;
      s_q   <= s_nx;
      t_q   <= t_nx;
    end
  end

  // Next-state and status decode. The status outputs depend on state only.
  always_comb begin
    state_nx  = state;
    s_nx      = s_q;
    t_nx      = t_q;
    busy      = 1'b0;
    done      = 1'b0;
    tgt_ready = 1'b0;
    case (state)
      IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          t_nx     = tgt;
          state_nx = (tgt != s_q) ? STEP : DONE;
        end
      end
      STEP: begin
        busy = 1'b1;
        s_nx = s_q ^ pick;
        // The step shown this cycle always commits, even when aborting
        if (abort)           state_nx = IDLE;
        else if (s_nx == t_q) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar g = 0; g < W; g++) begin : g_lane
    jk_drive_lane u_lane (
      .sel (step_sel[g]),
      .t   (t_q[g]),
      .j   (J[g]),
      .k   (K[g])
    );
  end
endmodule
